// File: rtl/uart_cmd_responder_if.sv
// Signal bundle between the command responder and its UART receiver/transmitter.
// The master side drives received bytes and transmitter status; the slave side replies.
interface uart_cmd_responder_if;
    logic [7:0] rx_data;
    logic       data_ready;
    logic       tx_busy;
    logic       clr_err;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] ctrl_reg;
    logic       frame_err;
    logic       ovr_err;

    modport master (
        output rx_data, data_ready, tx_busy, clr_err,
        input  tx_start, tx_data, ctrl_reg, frame_err, ovr_err
    );

    modport slave (
        input  rx_data, data_ready, tx_busy, clr_err,
        output tx_start, tx_data, ctrl_reg, frame_err, ovr_err
    );
endinterface

// File: rtl/uart_cmd_responder.sv
// Parses 'W' addr data / 'R' addr frames into a 16 x 8 register file and answers each
// frame with a single reply byte handed to the UART transmitter.
module uart_cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input logic                 clk,
    input logic                 rst,
    uart_cmd_responder_if.slave bus
);
    localparam logic [7:0]  CmdWrite = 8'h57;
    localparam logic [7:0]  CmdRead  = 8'h52;
    localparam logic [7:0]  ReplyAck = 8'h4B;
    localparam logic [7:0]  ReplyErr = 8'h3F;
    localparam logic [16:0] TmoLast  = 17'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StGetAddr, StGetData, StSend, StWaitBusy, StWaitDone
    } state_t;

    state_t      state;
    logic        is_write;
    logic [3:0]  addr;
    logic [16:0] tmo_cnt;
    logic [3:0]  busy_cnt;
    logic [7:0]  regs [16];

    assign bus.ctrl_reg = regs[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            is_write      <= 1'b0;
            addr          <= 4'h0;
            tmo_cnt       <= 17'd0;
            busy_cnt      <= 4'd0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= 8'h00;
            bus.frame_err <= 1'b0;
            bus.ovr_err   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            bus.tx_start <= 1'b0;
            // Clear first so that an error raised below in the same cycle wins.
            if (bus.clr_err) begin
                bus.frame_err <= 1'b0;
                bus.ovr_err   <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    tmo_cnt <= 17'd0;
                    if (bus.data_ready) begin
                        if (bus.rx_data == CmdWrite || bus.rx_data == CmdRead) begin
                            is_write <= (bus.rx_data == CmdWrite);
                            state    <= StGetAddr;
                        end else begin
                            bus.tx_data   <= ReplyErr;
                            bus.frame_err <= 1'b1;
                            state         <= StSend;
                        end
                    end
                end
                StGetAddr: begin
                    if (bus.data_ready) begin
                        tmo_cnt <= 17'd0;
                        addr    <= bus.rx_data[3:0];
                        if (bus.rx_data > 8'h0F) begin
                            bus.tx_data   <= ReplyErr;
                            bus.frame_err <= 1'b1;
                            state         <= StSend;
                        end else if (is_write) begin
                            state <= StGetData;
                        end else begin
                            bus.tx_data <= regs[bus.rx_data[3:0]];
                            state       <= StSend;
                        end
                    end else if (tmo_cnt == TmoLast) begin
                        tmo_cnt       <= 17'd0;
                        bus.frame_err <= 1'b1;
                        state         <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + 17'd1;
                    end
                end
                StGetData: begin
                    if (bus.data_ready) begin
                        tmo_cnt     <= 17'd0;
                        regs[addr]  <= bus.rx_data;
                        bus.tx_data <= ReplyAck;
                        state       <= StSend;
                    end else if (tmo_cnt == TmoLast) begin
                        tmo_cnt       <= 17'd0;
                        bus.frame_err <= 1'b1;
                        state         <= StIdle;
                    end else begin
                        tmo_cnt <= tmo_cnt + 17'd1;
                    end
                end
                StSend: begin
                    if (bus.data_ready) bus.ovr_err <= 1'b1;
                    if (!bus.tx_busy) begin
                        bus.tx_start <= 1'b1;
                        busy_cnt     <= 4'd0;
                        state        <= StWaitBusy;
                    end
                end
                StWaitBusy: begin
                    if (bus.data_ready) bus.ovr_err <= 1'b1;
                    // A transmitter that never acknowledges within 16 cycles abandons the reply.
                    if (bus.tx_busy) begin
                        state <= StWaitDone;
                    end else if (busy_cnt == 4'd15) begin
                        bus.frame_err <= 1'b1;
                        state         <= StIdle;
                    end else begin
                        busy_cnt <= busy_cnt + 4'd1;
                    end
                end
                StWaitDone: begin
                    if (bus.data_ready) bus.ovr_err <= 1'b1;
                    if (!bus.tx_busy) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: drives byte frames and a simple transmitter
// model, comparing replies, flags and timing against hand-computed values.
module tb_uart_cmd_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy_auto = 1'b0;
    logic busy_man = 1'b0;
    bit   auto_tx = 1'b1;
    int   busy_left = 0;
    int   cyc = 0;
    int   n_starts = 0;
    int   start_cyc = 0;
    int   busy_viol = 0;
    int   last_dr_cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] replies [$];

    uart_cmd_responder_if bus ();

    uart_cmd_responder #(.TIMEOUT_CYCLES(50)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_busy = busy_auto | busy_man;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Transmitter model: records each tx_start and, in auto mode, stays busy for 5 cycles.
    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) begin
            if (bus.tx_busy === 1'b1) busy_viol = busy_viol + 1;
            replies.push_back(bus.tx_data);
            n_starts  = n_starts + 1;
            start_cyc = cyc;
        end
        if (busy_left > 0) begin
            busy_left = busy_left - 1;
            if (busy_left == 0) busy_auto = 1'b0;
        end
        if (bus.tx_start === 1'b1 && auto_tx) begin
            busy_auto = 1'b1;
            busy_left = 5;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data    = b;
        bus.data_ready = 1'b1;
        last_dr_cyc    = cyc;
        @(negedge clk);
        bus.data_ready = 1'b0;
    endtask

    task automatic get_reply(output logic [7:0] b, output bit got);
        got = 1'b0;
        b   = 8'hxx;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (replies.size() > 0) begin
                b   = replies.pop_front();
                got = 1'b1;
            end
        end
        for (int i = 0; i < 20; i++) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    task automatic wait_busy(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_busy === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.tx_start !== 1'b0) begin
            miscompares++; $display("FAIL reset_tx_start got %b want 0", bus.tx_start);
        end
        vectors++;
        if (bus.tx_data !== 8'h00) begin
            miscompares++; $display("FAIL reset_tx_data got %h want 00", bus.tx_data);
        end
        vectors++;
        if (bus.ctrl_reg !== 8'h00) begin
            miscompares++; $display("FAIL reset_ctrl_reg got %h want 00", bus.ctrl_reg);
        end
        vectors++;
        if (bus.frame_err !== 1'b0 || bus.ovr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b%b want 00", bus.frame_err, bus.ovr_err);
        end
    endtask

    task automatic test_write_read();
        logic [7:0] b;
        bit got;
        send_byte(8'h57);
        send_byte(8'h00);
        vectors++;
        if (bus.ctrl_reg !== 8'h00) begin
            miscompares++; $display("FAIL wr_ctrl_early got %h want 00", bus.ctrl_reg);
        end
        send_byte(8'hA5);
        vectors++;
        if (bus.ctrl_reg !== 8'hA5) begin
            miscompares++; $display("FAIL wr_ctrl_reg got %h want a5", bus.ctrl_reg);
        end
        get_reply(b, got);
        vectors++;
        if (!got || b !== 8'h4B) begin
            miscompares++; $display("FAIL wr_reply got %h (seen %0d) want 4b", b, got);
        end
        vectors++;
        if (start_cyc - last_dr_cyc != 2) begin
            miscompares++;
            $display("FAIL wr_latency got %0d want 2", start_cyc - last_dr_cyc);
        end
        send_byte(8'h52);
        send_byte(8'h00);
        get_reply(b, got);
        vectors++;
        if (!got || b !== 8'hA5) begin
            miscompares++; $display("FAIL rd_reply got %h (seen %0d) want a5", b, got);
        end
        vectors++;
        if (bus.frame_err !== 1'b0 || bus.ovr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rd_flags got %b%b want 00", bus.frame_err, bus.ovr_err);
        end
    endtask

    task automatic test_bad_input();
        logic [7:0] b;
        bit got;
        send_byte(8'h41);
        get_reply(b, got);
        vectors++;
        if (!got || b !== 8'h3F) begin
            miscompares++; $display("FAIL bad_cmd_reply got %h want 3f", b);
        end
        vectors++;
        if (bus.frame_err !== 1'b1) begin
            miscompares++; $display("FAIL bad_cmd_frame_err got %b want 1", bus.frame_err);
        end
        pulse_clr();
        vectors++;
        if (bus.frame_err !== 1'b0) begin
            miscompares++; $display("FAIL clr_frame_err got %b want 0", bus.frame_err);
        end
        send_byte(8'h52);
        send_byte(8'h20);
        get_reply(b, got);
        vectors++;
        if (!got || b !== 8'h3F || bus.frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_rd_addr got %h/%b want 3f/1", b, bus.frame_err);
        end
        pulse_clr();
        send_byte(8'h57);
        send_byte(8'h10);
        send_byte(8'h55);
        get_reply(b, got);
        vectors++;
        if (!got || b !== 8'h3F || bus.frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_wr_addr got %h/%b want 3f/1", b, bus.frame_err);
        end
        vectors++;
        if (bus.ctrl_reg !== 8'hA5 || replies.size() != 0) begin
            miscompares++;
            $display("FAIL bad_wr_unchanged got %h/%0d want a5/0", bus.ctrl_reg, replies.size());
        end
        pulse_clr();
    endtask

    task automatic test_timeout();
        logic [7:0] b;
        bit got;
        int base;
        base = n_starts;
        send_byte(8'h57);
        repeat (48) @(negedge clk);
        vectors++;
        if (bus.frame_err !== 1'b0) begin
            miscompares++; $display("FAIL tmo_early got %b want 0", bus.frame_err);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.frame_err !== 1'b1) begin
            miscompares++; $display("FAIL tmo_frame_err got %b want 1", bus.frame_err);
        end
        repeat (5) @(negedge clk);
        vectors++;
        if (n_starts != base) begin
            miscompares++; $display("FAIL tmo_no_reply got %0d starts want %0d", n_starts, base);
        end
        send_byte(8'h52);
        send_byte(8'h03);
        get_reply(b, got);
        vectors++;
        if (!got || b !== 8'h00) begin
            miscompares++; $display("FAIL tmo_read_after got %h want 00", b);
        end
        pulse_clr();
    endtask

    task automatic test_overrun();
        logic [7:0] b;
        bit got;
        bit seen;
        send_byte(8'h52);
        send_byte(8'h00);
        wait_busy(seen);
        send_byte(8'h33);
        get_reply(b, got);
        vectors++;
        if (!seen || !got || b !== 8'hA5) begin
            miscompares++; $display("FAIL ovr_reply got %h want a5", b);
        end
        vectors++;
        if (bus.ovr_err !== 1'b1 || bus.frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_flags got %b%b want 01", bus.frame_err, bus.ovr_err);
        end
        send_byte(8'h52);
        send_byte(8'h01);
        wait_busy(seen);
        @(negedge clk);
        bus.rx_data    = 8'h44;
        bus.data_ready = 1'b1;
        bus.clr_err    = 1'b1;
        @(negedge clk);
        bus.data_ready = 1'b0;
        bus.clr_err    = 1'b0;
        vectors++;
        if (bus.ovr_err !== 1'b1) begin
            miscompares++; $display("FAIL ovr_set_wins got %b want 1", bus.ovr_err);
        end
        get_reply(b, got);
        vectors++;
        if (!got || b !== 8'h00) begin
            miscompares++; $display("FAIL ovr_reply2 got %h want 00", b);
        end
        pulse_clr();
        vectors++;
        if (bus.ovr_err !== 1'b0) begin
            miscompares++; $display("FAIL ovr_clear got %b want 0", bus.ovr_err);
        end
    endtask

    task automatic test_handshake();
        int base;
        int t;
        base    = n_starts;
        auto_tx = 1'b0;
        replies.delete();
        busy_man = 1'b1;
        send_byte(8'h57);
        send_byte(8'h05);
        send_byte(8'h3C);
        repeat (20) @(negedge clk);
        vectors++;
        if (n_starts != base) begin
            miscompares++; $display("FAIL hs_held got %0d starts want %0d", n_starts, base);
        end
        busy_man = 1'b0;
        t = cyc;
        repeat (2) @(negedge clk);
        busy_man = 1'b1;
        vectors++;
        if (n_starts != base + 1 || start_cyc != t + 1) begin
            miscompares++;
            $display("FAIL hs_start got %0d starts at %0d want %0d at %0d",
                     n_starts, start_cyc, base + 1, t + 1);
        end
        vectors++;
        if (replies.size() != 1 || replies[0] !== 8'h4B) begin
            miscompares++; $display("FAIL hs_reply got %0d bytes want one 4b", replies.size());
        end
        repeat (3) @(negedge clk);
        busy_man = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (n_starts != base + 1) begin
            miscompares++; $display("FAIL hs_single got %0d starts want %0d", n_starts, base + 1);
        end
        // Transmitter never acknowledges: reply is abandoned with frame_err.
        send_byte(8'h41);
        repeat (30) @(negedge clk);
        vectors++;
        if (bus.frame_err !== 1'b1 || n_starts != base + 2) begin
            miscompares++;
            $display("FAIL hs_busy_timeout got %b/%0d want 1/%0d",
                     bus.frame_err, n_starts, base + 2);
        end
        vectors++;
        if (busy_viol != 0) begin
            miscompares++; $display("FAIL hs_start_while_busy got %0d want 0", busy_viol);
        end
        auto_tx = 1'b1;
        replies.delete();
        pulse_clr();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        bit got;
        int base;
        base = n_starts;
        send_byte(8'h57);
        send_byte(8'h07);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        vectors++;
        if (n_starts != base || bus.ctrl_reg !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_mid got %0d starts ctrl %h want %0d/00",
                     n_starts, bus.ctrl_reg, base);
        end
        send_byte(8'h52);
        send_byte(8'h07);
        get_reply(b, got);
        vectors++;
        if (!got || b !== 8'h00) begin
            miscompares++; $display("FAIL rst_mid_read got %h want 00", b);
        end
    endtask

    initial begin
        bus.rx_data    = 8'h00;
        bus.data_ready = 1'b0;
        bus.clr_err    = 1'b0;
        test_reset();
        test_write_read();
        test_bad_input();
        test_timeout();
        test_overrun();
        test_handshake();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, as declared in REQ-003 and REQ-004.
REQ-002 Parameter: TIMEOUT_CYCLES, default 100000, idle clocks allowed between bytes of one frame; timeout counter 17 bits wide.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 data_ready  input  1  single-cycle strobe; rx_data valid in that cycle.
REQ-007 tx_busy  input  1  UART transmitter busy flag.
REQ-008 clr_err  input  1  clears sticky error flags.
REQ-009 tx_start  output  1  registered one-cycle request to transmit tx_data.
REQ-010 tx_data  output  8  registered reply byte; stable from tx_start until the reply completes.
REQ-011 ctrl_reg  output  8  live contents of register 0.
REQ-012 frame_err  output  1  sticky flag: bad command, bad address, or timeout.
REQ-013 ovr_err  output  1  sticky flag: byte arrived while a reply was in progress.

Function
REQ-014 The block SHALL hold a 16 x 8 register file, addressed by a full 8-bit address; only addresses 0x00-0x0F are valid.
REQ-015 Write frame: 0x57 ('W'), addr, data; on valid addr, the register is written at the edge that samples the data byte, and the reply is 0x4B ('K').
REQ-016 Read frame: 0x52 ('R'), addr; the reply is the register contents.
REQ-017 A first byte other than 0x57 or 0x52 SHALL produce reply 0x3F ('?') and set frame_err.
REQ-018 An addr greater than 0x0F SHALL produce reply 0x3F, leave the register file unchanged, and set frame_err.
REQ-019 FSM states: IDLE, GET_ADDR, GET_DATA, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE -> GET_ADDR on 'W' or 'R'.
- IDLE -> SEND on any other byte.
- GET_ADDR -> GET_DATA on byte, if the command is W with valid addr.
- GET_ADDR -> SEND on byte otherwise.
- GET_DATA -> SEND on byte.
REQ-020 SEND: when tx_busy is low, the block SHALL register tx_start=1 for exactly one cycle and enter WAIT_BUSY; while tx_busy is high it SHALL stay in SEND.
REQ-021 WAIT_BUSY -> WAIT_DONE when tx_busy is high; if tx_busy has not risen after 16 cycles, go to IDLE and set frame_err.
REQ-022 WAIT_DONE -> IDLE when tx_busy is low.
REQ-023 Latency: a frame's final data_ready in cycle N with tx_busy low SHALL give tx_start high in cycle N+2.
REQ-024 In GET_ADDR and GET_DATA, the timeout counter increments each cycle without data_ready and clears on data_ready.
REQ-025 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM SHALL go to IDLE, set frame_err, and send no reply.
REQ-026 A data_ready seen in SEND, WAIT_BUSY or WAIT_DONE SHALL be discarded and SHALL set ovr_err; the FSM is unaffected.
REQ-027 clr_err clears both flags next cycle; if an error sets in the same cycle, set wins for that flag.
REQ-028 A write to register 0 SHALL be visible on ctrl_reg in the cycle after the data byte's data_ready.
REQ-029 tx_start SHALL never be asserted while tx_busy is high, and never twice for one frame.

Reset
REQ-030 rst SHALL force:
- FSM to IDLE;
- the register file to all 0x00;
- tx_start=0, tx_data=0x00, ctrl_reg=0x00;
- frame_err=0, ovr_err=0;
- the timeout counter to 0.
REQ-031 rst asserted mid-frame or mid-reply SHALL abort with no further tx_start; rst has priority over all other inputs.

Verification
REQ-032 Write then read: W,0x00,0xA5 then R,0x00 -> replies 0x4B then 0xA5; ctrl_reg=0xA5 one cycle after the third byte.
REQ-033 Bad input:
- byte 0x41 -> reply 0x3F, frame_err=1.
- R,0x20 -> reply 0x3F, frame_err=1.
- W,0x10,0x55 -> reply 0x3F, registers unchanged.
REQ-034 Timeout: TIMEOUT_CYCLES=50, send 'W' then idle 50 cycles -> FSM in IDLE, frame_err=1, no tx_start; a following R,0x03 -> reply 0x00.
REQ-035 Overrun: inject data_ready during WAIT_DONE -> ovr_err=1, reply completes normally; pulsing clr_err together with a new overrun -> ovr_err stays 1.
REQ-036 Handshake: hold tx_busy high for 20 cycles at frame end -> tx_start asserted in the cycle after tx_busy falls, single pulse; reset in GET_DATA -> no reply, registers 0x00.
